fp_norm_round: RTL and testbench
================================

# fp_norm_round

Post-addition normalize-and-round stage of the single-precision floating-point adder. It sits directly downstream of the mantissa adder and its control unit. It consumes the raw 25-bit sum (carry, hidden, fraction), the common (larger) exponent, the sign and guard/round/sticky bits. It normalizes iteratively, one bit per cycle, then applies round-to-nearest-even and emits a packed IEEE-754 word under a valid/ready handshake.

## Interface
- EXP_W, 8, exponent width (biased)
- FRAC_W, 23, stored fraction width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  stage can accept (high only in IDLE)
- in_sign  input  1  result sign
- in_exp  input  EXP_W  common biased exponent before normalization
- in_mant  input  FRAC_W+2  {carry, hidden, fraction} raw sum
- in_grs  input  3  {guard, round, sticky} from alignment
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- out_result  output  1+EXP_W+FRAC_W  packed {sign, exp, frac}
- out_zero, out_ovf, out_unf  output  1 each  exact zero, overflow to infinity, flush-to-zero underflow

## Operation
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0, internal registers 0.
- IDLE: when in_valid && in_ready, capture inputs. Internal exponent is EXP_W+1 bits wide. Go to NORM.
- NORM (one evaluation per cycle, in priority order):
  - mant==0 && grs==0: result {sign,0,0}, zero=1, go to OUT.
  - mant[MSB]=1: shift right 1; old LSB moves to guard; guard|round|sticky fold into round/sticky; exp+1; go to ROUND.
  - mant[MSB-1]=1: go to ROUND.
  - exp<=1: flush to {sign,0,0}, unf=1, go to OUT.
  - Otherwise: shift left 1 with guard entering LSB, round→guard, 0→round, sticky kept; exp-1; stay in NORM.
- ROUND (RNE): increment when G && (R || S || LSB).
  - If the increment carries into mant[MSB]: shift right 1, exp+1.
  - If exp>=2^EXP_W-1: result {sign,all-ones,0}, ovf=1.
  - Otherwise: result {sign, exp, mant[FRAC_W-1:0]}.
  - Go to OUT.
- OUT: out_valid=1. out_result and flags stay stable until out_ready. On out_valid && out_ready, go to IDLE. out_valid falls the next cycle.
- in_ready is 0 in NORM, ROUND and OUT. No new operand overlaps an in-flight one.
- in_exp=0 with nonzero mant takes the flush path.

## Timing
- Acceptance edge E0. With k left shifts, out_valid is high after edge E(2+k).
  - k=0: out_valid after E2.
  - Maximum k=FRAC_W+1 (24): latency 26 cycles.
- Right shift on carry costs no extra cycle; it happens inside the NORM cycle.
- Back-to-back throughput: next acceptance is possible the cycle after the output handshake.
- rst_n low at any time: asynchronous return to IDLE with reset output values. An in-flight result is discarded. Release rst_n synchronously to clk.
- out_ready high before out_valid has no effect.

## Structure
- Shared package fp_pkg holds:
  - state enum {IDLE, NORM, ROUND, OUT}
  - EXP_W, FRAC_W
  - EXP_BIAS=127
  - EXP_MAX=2^EXP_W-1
  - packed-result field positions
- Sub-module fp_round_rne: combinational rounding. It takes {mant, grs} and produces {rounded mant, carry}. It is reused by a future multiplier.
- The FSM, shift registers and exponent counter live in fp_norm_round.

## Test plan
- 1.0+1.0: sign 0, exp 127, mant 25'h1000000, grs 0 → out_result 32'h40000000, flags 0, out_valid after E2.
- Cancellation: exp 130, mant 25'h0200000, grs 0 → 2 left shifts, out_result 32'h40000000, out_valid after E4.
- RNE rounding, exp 127, grs 3'b100:
  - mant 25'h0800001 → 32'h3F800002.
  - mant 25'h0800000 → 32'h3F800000 (tie, even kept).
- Round carry: exp 127, mant 25'h0FFFFFF, grs 3'b110 → 32'h40000000. Overflow: exp 254, mant 25'h1000000 → 32'h7F800000, out_ovf=1.
- Zero/underflow:
  - mant 0, grs 0, sign 1 → 32'h80000000, out_zero=1.
  - exp 1, mant 25'h0000001 → 32'h00000000, out_unf=1.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles → out_result stable and in_ready=0 throughout.
  - Assert rst_n=0 mid-NORM → immediately out_valid=0 and in_ready=1; the next operand processes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision formats, FSM states and result packing
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = (1 << EXP_W) - 1;

    // raw adder sum is {carry, hidden, fraction}
    localparam int MANT_W   = FRAC_W + 2;
    localparam int RES_W    = 1 + EXP_W + FRAC_W;

    localparam int SIGN_POS = RES_W - 1;
    localparam int EXP_MSB  = FRAC_W + EXP_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int FRAC_MSB = FRAC_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic logic [RES_W-1:0] pack_result(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        logic [RES_W-1:0] r;
        r                   = '0;
        r[SIGN_POS]         = sign;
        r[EXP_MSB:EXP_LSB]  = exp;
        r[FRAC_MSB:0]       = frac;
        return r;
    endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// rtl/fp_norm_round_if.sv - operand and result handshake bundle for the normalize/round stage
interface fp_norm_round_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic [2:0]        in_grs;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ovf, out_unf
    );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even increment on a normalized mantissa
module fp_round_rne #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W-1:0] mant,
    input  logic [2:0]        grs,
    output logic [MANT_W-1:0] mant_rnd,
    output logic              carry
);

    logic inc;

    // ties (G=1, R=S=0) only round up when that makes the LSB even
    assign inc = grs[2] & (grs[1] | grs[0] | mant[0]);

    assign {carry, mant_rnd} = {1'b0, mant} + {{MANT_W{1'b0}}, inc};

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - iterative post-add normalize, RNE round and IEEE-754 pack stage
module fp_norm_round
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_round_if.slave bus
);

    state_t            state;
    logic              sign_r;
    logic [EXP_W:0]    exp_r;
    logic [MANT_W-1:0] mant_r;
    logic [2:0]        grs_r;
    logic [RES_W-1:0]  result_r;
    logic              zero_r;
    logic              ovf_r;
    logic              unf_r;

    logic [FRAC_W:0]   rnd_mant;
    logic              rnd_carry;
    logic [EXP_W:0]    exp_rnd;
    logic [FRAC_W-1:0] frac_rnd;
    logic              round_ovf;

    // in ROUND the carry bit is already clear, so only {hidden, fraction} is rounded
    fp_round_rne #(
        .MANT_W (FRAC_W + 1)
    ) u_round (
        .mant     (mant_r[FRAC_W:0]),
        .grs      (grs_r),
        .mant_rnd (rnd_mant),
        .carry    (rnd_carry)
    );

    assign exp_rnd   = exp_r + {{EXP_W{1'b0}}, rnd_carry};
    assign frac_rnd  = rnd_carry ? rnd_mant[FRAC_W:1] : rnd_mant[FRAC_W-1:0];
    assign round_ovf = (exp_rnd >= (EXP_W+1)'(EXP_MAX));

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == OUT);
    assign bus.out_result = result_r;
    assign bus.out_zero   = zero_r;
    assign bus.out_ovf    = ovf_r;
    assign bus.out_unf    = unf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            grs_r    <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= bus.in_sign;
                        exp_r  <= {1'b0, bus.in_exp};
                        mant_r <= bus.in_mant;
                        grs_r  <= bus.in_grs;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (mant_r == '0 && grs_r == '0) begin
                        result_r <= pack_result(sign_r, '0, '0);
                        zero_r   <= 1'b1;
                        ovf_r    <= 1'b0;
                        unf_r    <= 1'b0;
                        state    <= OUT;
                    end else if (mant_r[MANT_W-1]) begin
                        // carry out of the adder: the dropped LSB becomes guard, the rest is sticky
                        mant_r <= {1'b0, mant_r[MANT_W-1:1]};
                        grs_r  <= {mant_r[0], grs_r[2], grs_r[1] | grs_r[0]};
                        exp_r  <= exp_r + 1'b1;
                        state  <= ROUND;
                    end else if (mant_r[MANT_W-2]) begin
                        state <= ROUND;
                    end else if (exp_r <= (EXP_W+1)'(1)) begin
                        result_r <= pack_result(sign_r, '0, '0);
                        zero_r   <= 1'b0;
                        ovf_r    <= 1'b0;
                        unf_r    <= 1'b1;
                        state    <= OUT;
                    end else begin
                        mant_r <= {mant_r[MANT_W-2:0], grs_r[2]};
                        grs_r  <= {grs_r[1], 1'b0, grs_r[0]};
                        exp_r  <= exp_r - 1'b1;
                    end
                end
                ROUND: begin
                    if (round_ovf) begin
                        result_r <= pack_result(sign_r, '1, '0);
                    end else begin
                        result_r <= pack_result(sign_r, exp_rnd[EXP_W-1:0], frac_rnd);
                    end
                    zero_r <= 1'b0;
                    ovf_r  <= round_ovf;
                    unf_r  <= 1'b0;
                    state  <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - directed vector bench for fp_norm_round
module tb_fp_norm_round;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [31:0] res;
        logic [2:0]  flags;   // {zero, ovf, unf}
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[16];

    fp_norm_round_if bus ();

    fp_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic send(input vec_t v, input bit early);
        @(negedge clk);
        check({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_sign   = v.sign;
        bus.in_exp    = v.exp;
        bus.in_mant   = v.mant;
        bus.in_grs    = v.grs;
        bus.out_ready = early;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus.out_valid && cnt < 40);
    endtask

    task automatic run_vec(input vec_t v, input bit early);
        int cnt;
        send(v, early);
        wait_valid(cnt);
        check({v.name, " latency"}, 32'(cnt), 32'(v.lat));
        check({v.name, " result"}, bus.out_result, v.res);
        check({v.name, " flags"}, 32'({bus.out_zero, bus.out_ovf, bus.out_unf}), 32'(v.flags));
        if (!early) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({v.name, " valid drop"}, 32'(bus.out_valid), 32'd0);
        check({v.name, " ready back"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   cnt;
        logic [31:0] held;

        total = 0;
        bad   = 0;
        vecs[0]  = '{"one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2};
        vecs[1]  = '{"cancel2",      1'b0, 8'd130, 25'h0200000, 3'b000, 32'h40000000, 3'b000, 4};
        vecs[2]  = '{"rne_up",       1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b000, 2};
        vecs[3]  = '{"rne_tie_even", 1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b000, 2};
        vecs[4]  = '{"round_carry",  1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h40000000, 3'b000, 2};
        vecs[5]  = '{"ovf_shift",    1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b010, 2};
        vecs[6]  = '{"neg_zero",     1'b1, 8'd100, 25'h0000000, 3'b000, 32'h80000000, 3'b100, 1};
        vecs[7]  = '{"unf_exp1",     1'b0, 8'd1,   25'h0000001, 3'b000, 32'h00000000, 3'b001, 1};
        vecs[8]  = '{"left_guard",   1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 3'b000, 3};
        vecs[9]  = '{"unf_shifts",   1'b0, 8'd3,   25'h0000001, 3'b000, 32'h00000000, 3'b001, 3};
        vecs[10] = '{"max_shift",    1'b0, 8'd127, 25'h0000000, 3'b100, 32'h33800000, 3'b000, 26};
        vecs[11] = '{"sticky_up",    1'b0, 8'd127, 25'h0800000, 3'b101, 32'h3F800001, 3'b000, 2};
        vecs[12] = '{"neg_one",      1'b1, 8'd127, 25'h0800000, 3'b000, 32'hBF800000, 3'b000, 2};
        vecs[13] = '{"rshift_tie",   1'b0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 3'b000, 2};
        vecs[14] = '{"rshift_up",    1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b000, 2};
        vecs[15] = '{"ovf_round",    1'b0, 8'd254, 25'h0FFFFFF, 3'b110, 32'h7F800000, 3'b010, 2};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_grs    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.out_result, 32'h0);
        check("reset flags", 32'({bus.out_zero, bus.out_ovf, bus.out_unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], 1'b0);
        end

        // consumer ready asserted before the result exists
        run_vec(vecs[2], 1'b1);

        // backpressure: result and in_ready must hold while out_ready stays low
        send(vecs[1], 1'b0);
        wait_valid(cnt);
        check("hold latency", 32'(cnt), 32'd4);
        held = bus.out_result;
        check("hold first", held, 32'h40000000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("hold result", bus.out_result, 32'h40000000);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold release", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // asynchronous reset in the middle of a long normalization
        send(vecs[10], 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[4], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
